conv_window_ctrl: RTL and testbench
===================================

// Module: conv_window_ctrl
// PURPOSE
//  Sequencing controller for the streaming convolution front end. Tracks the raster
//  (row, col) position of incoming pixels and gates the line-buffer shift. Flags when
//  a full KxK window is resident and hands window coordinates to the MAC array over a
//  valid/ready handshake. Owns frame start, abort and completion.
// PARAMETERS
//  K        3   kernel size (window is KxK); K >= 2
//  COORD_W  16  width of row/col counters and cfg_width/cfg_height
// PORTS
//  clk         in   1        clock
//  rst         in   1        asynchronous active-high reset
//  start       in   1        begin frame (sampled in IDLE only)
//  abort       in   1        synchronous frame abort
//  cfg_width   in   COORD_W  image width in pixels, latched on start
//  cfg_height  in   COORD_W  image height in pixels, latched on start
//  in_valid    in   1        upstream pixel valid
//  in_ready    out  1        pixel accepted when in_valid & in_ready
//  lb_shift_en out  1        line-buffer shift strobe (= accept)
//  out_valid   out  1        window available
//  out_ready   in   1        MAC array accepts window
//  out_row     out  COORD_W  top row of window
//  out_col     out  COORD_W  left col of window
//  busy        out  1        state != IDLE
//  frame_done  out  1        1-cycle pulse at frame completion
//  cfg_err     out  1        1-cycle pulse: start rejected
// BEHAVIOUR
//  - Reset: state IDLE; row=col=0; all outputs 0.
//  - FSM IDLE->RUN on start if cfg_width>=K and cfg_height>=K; otherwise cfg_err pulses and stays IDLE.
//  - RUN->DRAIN when the last pixel (col==W-1, row==H-1) is accepted.
//  - DRAIN->IDLE once out_valid is 0 or its handshake completes; frame_done pulses that cycle.
//  - abort (any state): next cycle IDLE, out_valid=0, counters=0, no frame_done. abort beats start.
//  - in_ready = (state==RUN) & (~out_valid | out_ready). Single-entry output register, no bubbles.
//  - Accept: col wraps W-1->0 and row increments on wrap; row wraps H-1->0 only at frame end.
//  - Window: on accept of pixel (r,c) with r>=K-1 and c>=K-1, next cycle out_valid=1,
//    out_row=r-(K-1), out_col=c-(K-1). Latency 1 cycle.
//  - out_valid holds, and out_row/out_col stay stable, until out_ready.
//  - Simultaneous out_ready and a new window: register reloads and out_valid stays 1.
//  - Windows per frame = (W-K+1)*(H-K+1). Comparisons are unsigned; no overflow for W,H < 2^COORD_W.
// CONFIGURATION
//  - CONV_STRIDE_EN defined: adds input cfg_stride2 (1b, latched on start). When 1, a window
//    additionally requires out_row[0]==0 and out_col[0]==0. Pixels are still all accepted and shifted.
//  - CONV_STRIDE_EN undefined: port absent; stride fixed at 1.
// STRUCTURE
//  - conv_pkg: ctrl_state_e {IDLE,RUN,DRAIN}; K_MIN constant; coord_t typedef (COORD_W bits).
//  - Sub-module conv_pos_counter, instanced twice (col, row): enable, runtime wrap target,
//    async reset, wrap output.
// TESTING
//  - K=3, W=5, H=4, in_valid always, out_ready=1 -> 20 accepts, 6 windows. First out_valid is
//    the cycle after pixel 12 (r2,c2), (0,0); last is (1,2); frame_done 1 cycle after the last window.
//  - Same frame, out_ready low 3 cycles on window 2 -> in_ready low, out_row/out_col stable,
//    total still 6, no window lost.
//  - start with cfg_width=2 -> cfg_err pulse, busy stays 0, no lb_shift_en.
//  - abort after 8 accepts -> IDLE next cycle, out_valid 0, no frame_done. A new start with
//    W=H=3 then yields exactly one window (0,0).
//  - rst asserted mid-DRAIN -> all outputs 0 immediately, state IDLE after release.
//  - CONV_STRIDE_EN, cfg_stride2=1, W=H=6 -> windows (0,0),(0,2),(2,0),(2,2) only, 36 accepts.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front-end controller.
package conv_pkg;

  localparam int unsigned COORD_W_DEF = 16;
  localparam int unsigned K_MIN       = 2;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter: increments on en, wraps to 0 after wrap_at.
module conv_pos_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] wrap_at,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == wrap_at);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= wrap ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Streaming convolution window sequencer: raster tracking, window handshake, frame control.
// Optional CONV_STRIDE_EN adds cfg_stride2 (stride-2 window decimation).
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned K       = 3,
  parameter int unsigned COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
`ifdef CONV_STRIDE_EN
  input  logic               cfg_stride2,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  output logic               lb_shift_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam int unsigned KK = (K < K_MIN) ? K_MIN : K;
  localparam logic [COORD_W-1:0] K_SZ = COORD_W'(KK);
  localparam logic [COORD_W-1:0] KM1  = COORD_W'(KK - 1);

  ctrl_state_e        state;
  logic [COORD_W-1:0] w_l, h_l, col, row, win_row, win_col;
  logic               accept, col_wrap, last, win, stride_ok, cfg_ok;

  assign in_ready    = (state == RUN) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign lb_shift_en = accept;
  assign busy        = (state != IDLE);
  assign cfg_ok      = (cfg_width >= K_SZ) && (cfg_height >= K_SZ);

  conv_pos_counter #(.W(COORD_W)) u_col (
    .clk(clk), .rst(rst), .clr(abort), .en(accept),
    .wrap_at(w_l - COORD_W'(1)), .cnt(col), .wrap(col_wrap)
  );

  // Row only advances on a column wrap, so its wrap marks the frame's last pixel.
  conv_pos_counter #(.W(COORD_W)) u_row (
    .clk(clk), .rst(rst), .clr(abort), .en(col_wrap),
    .wrap_at(h_l - COORD_W'(1)), .cnt(row), .wrap(last)
  );

  assign win_row = row - KM1;
  assign win_col = col - KM1;

`ifdef CONV_STRIDE_EN
  logic s2_l;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s2_l <= 1'b0;
    else if (state == IDLE && start && !abort && cfg_ok)
      s2_l <= cfg_stride2;
  end
  assign stride_ok = !s2_l || (!win_row[0] && !win_col[0]);
`else
  assign stride_ok = 1'b1;
`endif

  assign win = accept && (row >= KM1) && (col >= KM1) && stride_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      w_l        <= '0;
      h_l        <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_row   <= '0;
        out_col   <= '0;
      end else begin
        // A new window overrides the consume so a same-cycle handshake reloads without a bubble.
        if (win) begin
          out_valid <= 1'b1;
          out_row   <= win_row;
          out_col   <= win_col;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                state <= RUN;
                w_l   <= cfg_width;
                h_l   <= cfg_height;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (last)
              state <= DRAIN;
          end
          DRAIN: begin
            if (!out_valid || out_ready) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized/directed bench for conv_window_ctrl against a raster-level reference model.
module tb_conv_window_ctrl;

  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid, out_ready;
  logic [15:0] cfg_width, cfg_height;
  logic        in_ready, lb_shift_en, out_valid, busy, frame_done, cfg_err;
  logic [15:0] out_row, out_col;
  bit          stride2;

  conv_window_ctrl #(.K(K), .COORD_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef CONV_STRIDE_EN
    .cfg_stride2(stride2),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .lb_shift_en(lb_shift_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain.
  int phase = 0, mw = 0, mh = 0, n_acc = 0, n_out = 0;
  bit ov = 0, fd_exp = 0, err_exp = 0, ms2 = 0;
  int er[$], ec[$];
  int dut_hs = 0, dut_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_win(input int r, input int c, input bit s2);
    if (r < K - 1 || c < K - 1) return 0;
    if (s2 && (((r - (K - 1)) % 2) != 0 || ((c - (K - 1)) % 2) != 0)) return 0;
    return 1;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check combinational outputs, advance model.
  task automatic cyc(input bit iv, input bit ordy, input bit st, input bit ab);
    bit mrdy, acc, neww;
    int r, c;
    check("out_valid", out_valid, ov);
    if (ov) begin
      check("out_row", out_row, er[n_out]);
      check("out_col", out_col, ec[n_out]);
    end
    check("busy", busy, phase != 0);
    check("frame_done", frame_done, fd_exp);
    check("cfg_err", cfg_err, err_exp);
    in_valid = iv; out_ready = ordy; start = st; abort = ab;
    #1;
    mrdy = (phase == 1) && (!ov || ordy);
    acc  = mrdy && iv;
    check("in_ready", in_ready, mrdy);
    check("lb_shift_en", lb_shift_en, acc);
    if (lb_shift_en) dut_acc++;
    if (out_valid && ordy) dut_hs++;
    fd_exp = 0; err_exp = 0;
    if (ab) begin
      phase = 0; ov = 0; n_acc = 0;
    end else if (phase == 0) begin
      if (st) begin
        if (cfg_width >= K && cfg_height >= K) begin
          phase = 1; mw = cfg_width; mh = cfg_height; n_acc = 0; n_out = 0;
`ifdef CONV_STRIDE_EN
          ms2 = stride2;
`else
          ms2 = 0;
`endif
          er.delete(); ec.delete();
          for (int rr = 0; rr < mh; rr++)
            for (int cc = 0; cc < mw; cc++)
              if (is_win(rr, cc, ms2)) begin er.push_back(rr - (K - 1)); ec.push_back(cc - (K - 1)); end
        end else begin
          err_exp = 1;
        end
      end
    end else begin
      neww = 0;
      if (acc) begin
        r = n_acc / mw; c = n_acc % mw;
        neww = is_win(r, c, ms2);
        n_acc++;
      end
      if (phase == 2 && (!ov || ordy)) begin phase = 0; fd_exp = 1; end
      if (ov && ordy) n_out++;
      ov = neww || (ov && !ordy);
      if (phase == 1 && n_acc == mw * mh) phase = 2;
    end
    @(posedge clk); #1;
  endtask

  // mode 0: full rate; 1: random valid/ready; 2: out_ready low 3 cycles on window 2.
  task automatic run_frame(input int w, input int h, input int mode, input bit s2);
    int n, lowcnt, expwin, expacc;
    bit iv, ordy, st;
    cfg_width = 16'(w); cfg_height = 16'(h); stride2 = s2;
    dut_hs = 0; dut_acc = 0; lowcnt = 0;
    cyc(0, 1, 1, 0);
    n = 0;
    while (phase != 0 && n < 3000) begin
      iv = 1; ordy = 1; st = 0;
      if (mode == 1) begin
        iv = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        st = ($urandom_range(0, 7) == 0);
      end else if (mode == 2 && n_out == 1 && ov && lowcnt < 3) begin
        ordy = 0; lowcnt++;
      end
      cyc(iv, ordy, st, 0);
      n++;
    end
    if (phase != 0) begin
      check("frame_timeout", n, 0);
      cyc(0, 1, 0, 1);
    end
    cyc(0, 1, 0, 0);
    if (w >= K && h >= K) begin
      expwin = s2 ? ((w - 1) / 2) * ((h - 1) / 2) : (w - K + 1) * (h - K + 1);
      expacc = w * h;
    end else begin
      expwin = 0; expacc = 0;
    end
    check("windows", dut_hs, expwin);
    check("accepts", dut_acc, expacc);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; out_ready = 0;
    cfg_width = 0; cfg_height = 0; stride2 = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_row", out_row, 0);
    check("rst_frame_done", frame_done, 0);
    #10 rst = 0;
    @(posedge clk); #1;

    run_frame(5, 4, 0, 0);
    run_frame(5, 4, 2, 0);

    // Rejected configuration: cfg_err pulse, no activity.
    cfg_width = 2; cfg_height = 4;
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

    // Abort after 8 accepts, then a minimal frame.
    cfg_width = 5; cfg_height = 4;
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 50 && n_acc < 8; i++) cyc(1, 1, 0, 0);
    check("abort_pos", n_acc, 8);
    cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 0);
    run_frame(3, 3, 0, 0);

    // Asynchronous reset while a window is pending in drain.
    cfg_width = 5; cfg_height = 4;
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 100 && phase != 2; i++) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("drain_reached", busy, 1);
    rst = 1; #1;
    check("rstd_out_valid", out_valid, 0);
    check("rstd_busy", busy, 0);
    check("rstd_in_ready", in_ready, 0);
    check("rstd_lb_shift", lb_shift_en, 0);
    check("rstd_out_row", out_row, 0);
    check("rstd_out_col", out_col, 0);
    #1 rst = 0;
    phase = 0; ov = 0; n_acc = 0; fd_exp = 0; err_exp = 0;
    @(posedge clk); #1;
    cyc(0, 1, 0, 0);

`ifdef CONV_STRIDE_EN
    run_frame(6, 6, 0, 1);
    run_frame(7, 5, 1, 1);
`endif

    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(2, 7), $urandom_range(3, 7), 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
